// File: rtl/nfc_req_if.sv
// Request-queue bus bundle: push side from the register file and the
// chunked issue side toward the NFC channel controller, plus status flags.
interface nfc_req_if #(
  parameter int DEPTH = 16
);
  logic [47:0]             nfc_lba;
  logic [23:0]             nfc_len;
  logic [15:0]             nfc_opcode;
  logic                    nfc_valid;
  logic                    ovf_clear;
  logic                    req_fifo_almost_full;
  logic                    req_fifo_overflow;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [47:0]             m_req_lba;
  logic [23:0]             m_req_len;
  logic [15:0]             m_req_opcode;
  logic                    m_req_last;
  logic                    m_req_valid;
  logic                    m_req_ready;

  modport slave (
    input  nfc_lba, nfc_len, nfc_opcode, nfc_valid, ovf_clear, m_req_ready,
    output req_fifo_almost_full, req_fifo_overflow, fifo_count,
           m_req_lba, m_req_len, m_req_opcode, m_req_last, m_req_valid
  );

  modport master (
    output nfc_lba, nfc_len, nfc_opcode, nfc_valid, ovf_clear, m_req_ready,
    input  req_fifo_almost_full, req_fifo_overflow, fifo_count,
           m_req_lba, m_req_len, m_req_opcode, m_req_last, m_req_valid
  );
endinterface

// File: rtl/nfc_req_queue.sv
// Command FIFO between the register file and the NFC controller; issues each
// queued request as MAX_CHUNK-sized sub-requests with advancing LBA.
module nfc_req_queue #(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int MAX_CHUNK = 8
) (
  input  logic     S_AXI_ACLK,
  input  logic     S_AXI_ARESET,
  nfc_req_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 48 + 24 + 16;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [23:0]   CHUNK   = 24'(MAX_CHUNK);
  localparam logic [47:0]   CHUNK48 = 48'(MAX_CHUNK);

  // LOAD is the single bubble cycle while the registered RAM read lands.
  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] rd_data_q;

  state_t        state_q,   state_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0] count_q,   count_d;
  logic          ovf_q,     ovf_d;
  logic [47:0]   cur_lba_q, cur_lba_d;
  logic [23:0]   rem_len_q, rem_len_d;
  logic [15:0]   cur_op_q,  cur_op_d;

  logic push, drop, pop, last, hs, issuing;

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.nfc_lba, bus.nfc_len, bus.nfc_opcode};
    end
    if (pop) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    push      = bus.nfc_valid && (count_q != DEPTH_C);
    drop      = bus.nfc_valid && (count_q == DEPTH_C);
    last      = (rem_len_q <= CHUNK);
    issuing   = (state_q == ISSUE);
    hs        = issuing && bus.m_req_ready;
    pop       = (count_q != '0) && ((state_q == IDLE) || (hs && last));

    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    ovf_d     = (ovf_q && !bus.ovf_clear) || drop;
    cur_lba_d = cur_lba_q;
    rem_len_d = rem_len_q;
    cur_op_d  = cur_op_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (pop) state_d = LOAD;
      end
      LOAD: begin
        cur_lba_d = rd_data_q[87:40];
        rem_len_d = rd_data_q[39:16];
        cur_op_d  = rd_data_q[15:0];
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (hs) begin
          if (last) begin
            // Back-to-back requests: prefetch the next head on the final beat.
            state_d = pop ? LOAD : IDLE;
          end else begin
            cur_lba_d = cur_lba_q + CHUNK48;
            rem_len_d = rem_len_q - CHUNK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cur_lba_q <= '0;
      rem_len_q <= '0;
      cur_op_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cur_lba_q <= cur_lba_d;
      rem_len_q <= rem_len_d;
      cur_op_q  <= cur_op_d;
    end
  end

  // Outputs are zeroed outside ISSUE so idle working registers never leak.
  assign bus.m_req_valid          = issuing;
  assign bus.m_req_lba            = issuing ? cur_lba_q : '0;
  assign bus.m_req_len            = issuing ? (last ? rem_len_q : CHUNK) : '0;
  assign bus.m_req_opcode         = issuing ? cur_op_q : '0;
  assign bus.m_req_last           = issuing && last;
  assign bus.fifo_count           = count_q;
  assign bus.req_fifo_almost_full = (count_q >= AF_C);
  assign bus.req_fifo_overflow    = ovf_q;
endmodule

// File: tb/tb_nfc_req_queue.sv
// Scoreboard bench for nfc_req_queue: directed scenarios plus randomized
// traffic, with expected beats expanded from each accepted request.
module tb_nfc_req_queue;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int MC    = 8;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  nfc_req_if #(.DEPTH(DEPTH)) bus();

  nfc_req_queue #(.DEPTH(DEPTH), .AF_THRESH(AF), .MAX_CHUNK(MC)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(srst),
    .bus         (bus)
  );

  typedef struct packed {
    logic [47:0] lba;
    logic [23:0] len;
    logic [15:0] op;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int outstanding = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference expansion of one request into its issued beats.
  task automatic expect_req(input logic [47:0] lba, input logic [23:0] len, input logic [15:0] op);
    logic [47:0] l;
    logic [23:0] r;
    bit done;
    l = lba;
    r = len;
    done = 0;
    while (!done) begin
      if (r <= 24'(MC)) begin
        exp_q.push_back({l, r, op, 1'b1});
        done = 1;
      end else begin
        exp_q.push_back({l, 24'(MC), op, 1'b0});
        l = l + 48'(MC);
        r = r - 24'(MC);
      end
    end
    outstanding++;
  endtask

  task automatic push_req(input logic [47:0] lba, input logic [23:0] len,
                          input logic [15:0] op, input bit accepted);
    bus.nfc_lba    = lba;
    bus.nfc_len    = len;
    bus.nfc_opcode = op;
    bus.nfc_valid  = 1'b1;
    if (accepted) expect_req(lba, len, op);
    tick();
    bus.nfc_valid  = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    check("drain_remaining", exp_q.size(), 0);
  endtask

  function automatic logic [47:0] rand_lba();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[47:0];
  endfunction

  // Monitor: compares every handshake against the scoreboard and checks
  // that a stalled beat holds stable until accepted.
  initial begin
    beat_t got, held, b;
    bit hold;
    hold = 0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {bus.m_req_lba, bus.m_req_len, bus.m_req_opcode, bus.m_req_last};
      if (srst) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("bp_valid_held", bus.m_req_valid, 1);
          check("bp_beat_stable", got, held);
        end
        if (bus.m_req_valid && bus.m_req_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected none", got);
          end else begin
            b = exp_q.pop_front();
            check("beat", got, b);
            if (b.last) outstanding--;
          end
        end
        hold = bus.m_req_valid && !bus.m_req_ready;
        held = got;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [47:0] l;
    int expc;
    bus.nfc_lba     = '0;
    bus.nfc_len     = '0;
    bus.nfc_opcode  = '0;
    bus.nfc_valid   = 1'b0;
    bus.ovf_clear   = 1'b0;
    bus.m_req_ready = 1'b0;
    repeat (3) tick();

    check("rst_valid", bus.m_req_valid, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_af", bus.req_fifo_almost_full, 0);
    check("rst_ovf", bus.req_fifo_overflow, 0);
    check("rst_fields", {bus.m_req_lba, bus.m_req_len, bus.m_req_opcode, bus.m_req_last}, 0);
    srst = 1'b0;
    tick();

    // 1: single short request, latency and count
    bus.m_req_ready = 1'b1;
    push_req(48'h0000_0000_1000, 24'd5, 16'h0030, 1);
    check("t1_valid_n", bus.m_req_valid, 0);
    check("t1_count_n", bus.fifo_count, 1);
    tick();
    check("t1_valid_n1", bus.m_req_valid, 0);
    check("t1_count_n1", bus.fifo_count, 0);
    tick();
    check("t1_valid_n2", bus.m_req_valid, 1);
    check("t1_beat", {bus.m_req_lba, bus.m_req_len, bus.m_req_opcode, bus.m_req_last},
          {48'h1000, 24'd5, 16'h0030, 1'b1});
    tick();
    check("t1_done_valid", bus.m_req_valid, 0);
    check("t1_done_count", bus.fifo_count, 0);

    // 2: LBA wrap across chunks, back-to-back beats
    push_req(48'hFFFF_FFFF_FFF8, 24'd20, 16'h0011, 1);
    tick();
    tick();
    check("t2_b0", {bus.m_req_valid, bus.m_req_lba, bus.m_req_len, bus.m_req_last},
          {1'b1, 48'hFFFF_FFFF_FFF8, 24'd8, 1'b0});
    tick();
    check("t2_b1", {bus.m_req_valid, bus.m_req_lba, bus.m_req_len, bus.m_req_last},
          {1'b1, 48'h0, 24'd8, 1'b0});
    tick();
    check("t2_b2", {bus.m_req_valid, bus.m_req_lba, bus.m_req_len, bus.m_req_last},
          {1'b1, 48'h8, 24'd4, 1'b1});
    tick();
    check("t2_idle", bus.m_req_valid, 0);

    // 3: zero-length op
    push_req(48'h0000_0000_0ABC, 24'd0, 16'h00FF, 1);
    tick();
    tick();
    check("t3_beat", {bus.m_req_valid, bus.m_req_len, bus.m_req_opcode, bus.m_req_last},
          {1'b1, 24'd0, 16'h00FF, 1'b1});
    tick();
    check("t3_idle", bus.m_req_valid, 0);

    // 4: backpressure on the first chunk
    bus.m_req_ready = 1'b0;
    push_req(48'h0000_1234_0000, 24'd16, 16'h0081, 1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold", {bus.m_req_valid, bus.m_req_lba, bus.m_req_len, bus.m_req_opcode, bus.m_req_last},
            {1'b1, 48'h0000_1234_0000, 24'd8, 16'h0081, 1'b0});
      tick();
    end
    bus.m_req_ready = 1'b1;
    tick();
    check("t4_chunk2", {bus.m_req_valid, bus.m_req_lba, bus.m_req_len, bus.m_req_last},
          {1'b1, 48'h0000_1234_0008, 24'd8, 1'b1});
    tick();
    check("t4_idle", bus.m_req_valid, 0);

    // 5: fill, almost-full, overflow, clear, drain in order
    bus.m_req_ready = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      push_req(rand_lba(), 24'($urandom_range(1, MC)), 16'($urandom), k <= 17);
      expc = (k == 1) ? 1 : ((k <= 17) ? k - 1 : 16);
      check("t5_count", bus.fifo_count, expc);
      check("t5_af", bus.req_fifo_almost_full, expc >= AF);
      check("t5_ovf", bus.req_fifo_overflow, k == 18);
    end
    repeat (3) tick();
    check("t5_ovf_sticky", bus.req_fifo_overflow, 1);
    bus.ovf_clear = 1'b1;
    tick();
    bus.ovf_clear = 1'b0;
    check("t5_ovf_cleared", bus.req_fifo_overflow, 0);
    bus.m_req_ready = 1'b1;
    drain(200);
    check("t5_outstanding", outstanding, 0);

    // Randomized traffic with random backpressure, never filling the FIFO
    for (int c = 0; c < 400; c++) begin
      bus.m_req_ready = ($urandom % 4) != 0;
      if (outstanding < 10 && ($urandom % 3) == 0)
        push_req(rand_lba(), 24'($urandom_range(0, 40)), 16'($urandom), 1);
      else
        tick();
    end
    bus.m_req_ready = 1'b1;
    drain(1000);
    check("rnd_ovf", bus.req_fifo_overflow, 0);
    check("rnd_count", bus.fifo_count, 0);

    // 6: reset during the second chunk with entries queued
    bus.m_req_ready = 1'b0;
    push_req(48'h0000_0000_0100, 24'd24, 16'h0042, 1);
    for (int i = 0; i < 3; i++) push_req(rand_lba(), 24'($urandom_range(1, 20)), 16'($urandom), 1);
    check("t6_count", bus.fifo_count, 3);
    check("t6_first", {bus.m_req_valid, bus.m_req_lba}, {1'b1, 48'h100});
    bus.m_req_ready = 1'b1;
    tick();
    bus.m_req_ready = 1'b0;
    l = 48'h108;
    check("t6_second", {bus.m_req_valid, bus.m_req_lba}, {1'b1, l});
    srst = 1'b1;
    exp_q.delete();
    outstanding = 0;
    tick();
    check("t6_rst_valid", bus.m_req_valid, 0);
    check("t6_rst_count", bus.fifo_count, 0);
    check("t6_rst_af", bus.req_fifo_almost_full, 0);
    tick();
    srst = 1'b0;
    bus.m_req_ready = 1'b1;
    repeat (20) tick();
    check("t6_no_stale", bus.m_req_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
